// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps an 8:1 mux select through channels 0..7 and assembles one sample per channel into a frame
//
// Ports:
//   clk_i           system clock, all state updates on the rising edge
//   reset_i         synchronous active-high reset
//   start_i         request one scan, honoured only in IDLE or DONE
//   continuous_i    when high, DONE goes straight back to SCAN
//   mux_out_i       output of the multiplexer being scanned
//   sel_o[2:0]      channel select driven to the multiplexer
//   busy_o          high while scanning
//   frame_o[7:0]    last completed frame, bit i sampled while sel_o == i
//   frame_valid_o   one-cycle pulse on the cycle frame_o updates
module mux_scan_sequencer #(
    parameter int DWELL = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       continuous_i,
    input  logic       mux_out_i,
    output logic [2:0] sel_o,
    output logic       busy_o,
    output logic [7:0] frame_o,
    output logic       frame_valid_o
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [7:0] LAST = 8'(DWELL - 1);
    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [2:0]  sel_q;
    logic [6:0]  shadow_q;
    logic [7:0]  frame_q;
    logic        busy_q;
    logic        valid_q;
    assign sel_o         = sel_q;
    assign busy_o        = busy_q;
    assign frame_o       = frame_q;
    assign frame_valid_o = valid_q;
    // Samples are taken on the last dwell cycle so the mux has DWELL-1 cycles to settle.
    // The shadow register shifts in from the top, so after channel 6 it holds {s6..s0}.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        sel_q   <= '0;
                    end
                end
                SCAN: begin
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        if (sel_q != 3'd7) begin
                            shadow_q <= {mux_out_i, shadow_q[6:1]};
                            sel_q    <= sel_q + 3'd1;
                        end else begin
                            frame_q <= {mux_out_i, shadow_q};
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                            sel_q   <= '0;
                            state_q <= DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                    sel_q   <= '0;
                    if (continuous_i || start_i) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream control stage for the 8:1 channel multiplexer: drives its 3-bit select through channels 0..7 in order and samples the multiplexer output once per channel.
- Assembles the eight samples into an 8-bit frame word and publishes it with a one-cycle valid pulse.
- Supports single-shot scans (on start) and free-running continuous scans.

Parameters:
- DWELL, 4, clock cycles sel is held per channel; sample taken on the last dwell cycle; legal range 2..255.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request one scan; sampled only in IDLE or DONE
- continuous  input  1  when 1, DONE returns to SCAN instead of IDLE
- mux_out  input  1  output of the 8:1 multiplexer being scanned
- sel  output  3  channel select driven to the multiplexer
- busy  output  1  high while in SCAN
- frame  output  8  last completed frame; frame[i] = mux_out sampled while sel == i
- frame_valid  output  1  one-cycle pulse when frame updates

Behaviour:
- Reset values (synchronous, every output registered): sel=0, busy=0, frame=8'h00, frame_valid=0, state=IDLE, dwell counter=0, shadow register=0.
- Reset asserted mid-scan aborts the scan at the next edge: no frame_valid, frame cleared to 0.
- States:
  - IDLE: sel=0, busy=0. start=1 -> SCAN with cnt=0, sel=0.
  - SCAN: busy=1. cnt increments every cycle.
    - When cnt==DWELL-1 and sel<7: shadow[sel]<=mux_out; sel<=sel+1; cnt<=0.
    - When cnt==DWELL-1 and sel==7: frame<={mux_out, shadow[6:0]}; frame_valid<=1; -> DONE.
  - DONE (exactly one cycle): frame_valid=1, busy=0, sel=0.
    - (continuous | start) -> SCAN with cnt=0.
    - Otherwise -> IDLE.
    - frame_valid<=0 on exit.
- Timing:
  - start seen at edge k: busy=1 and sel=0 from edge k.
  - Each channel is held exactly DWELL cycles.
  - Entry into DONE (frame_valid=1) at edge k+8*DWELL.
  - Continuous mode: frame_valid period is 8*DWELL+1 cycles.
- Start handling:
  - start during SCAN is ignored (no restart, no queuing).
  - start held high in IDLE behaves like continuous.
- Continuous handling: continuous dropped mid-scan lets the current frame complete, then IDLE.
- frame holds its value between pulses and changes only on the edge entering DONE (or on reset).
- sel never exceeds 7 and never wraps within a scan; each scan starts at sel=0.
- The sample taken on the last dwell cycle gives the combinational multiplexer DWELL-1 cycles to settle after each sel change.

Test Plan:
- Reset values: assert reset 2 cycles -> sel=0, busy=0, frame=8'h00, frame_valid=0; hold start=0 for 20 cycles -> all unchanged.
- Single scan: DWELL=4, multiplexer inputs a..h = 1,0,1,1,0,0,1,0, start pulsed at edge 0 -> all of the following:
  - sel steps 0..7, each value held 4 cycles.
  - busy high for 32 cycles.
  - frame_valid high for exactly 1 cycle after edge 32.
  - frame=8'h4D; IDLE afterwards.
- Continuous: continuous=1, same inputs; change h to 1 during the second scan -> frame_valid pulses 33 cycles apart; frames read 8'h4D, then 8'hCD.
- Start ignored: pulse start at cycle 10 of a scan -> no restart; sel sequence unaffected; one frame_valid only.
- Reset mid-scan: assert reset at cycle 15 of a scan -> next edge sel=0, busy=0, frame=8'h00; no frame_valid.
- Stop continuous: drop continuous at cycle 5 of a frame -> that frame completes with one frame_valid, then IDLE with busy=0.
